// File: rtl/mod_seq_div.sv
// mod_seq_div: sequential restoring divider with valid/ready handshakes.
// The WIDTH-bit unsigned dividend is divided by a runtime DWIDTH-bit
// divisor, MSB first, retiring BITS_PER_CYCLE quotient bits per clock.
// The remainder is always produced. The full quotient (out_quot and its
// shift register) is present only when the QUOTIENT_EN macro is defined;
// without it the block is remainder-only with identical timing.
module mod_seq_div #(
  parameter int WIDTH          = 32,
  parameter int DWIDTH         = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_data,
  input  logic [DWIDTH-1:0] in_div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DWIDTH-1:0] out_rem,
`ifdef QUOTIENT_EN
  output logic [WIDTH-1:0]  out_quot,
`endif
  output logic              out_div0
);

  // Number of BUSY cycles needed to consume the whole dividend.
  localparam int STEPS = WIDTH / BITS_PER_CYCLE;
  // Wide enough to hold STEPS, so the counter never wraps before DONE.
  localparam int CNT_W = $clog2(STEPS + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_reg;
  state_t            state_next;
  logic [CNT_W-1:0]  cnt_reg;
  logic [WIDTH-1:0]  dvd_reg;      // dividend, shifted left as bits are consumed
  logic [DWIDTH-1:0] div_reg;      // latched divisor
  logic [DWIDTH-1:0] rem_reg;      // partial remainder (always < divisor)
  logic              out_valid_reg;
  logic              div0_reg;
  logic [DWIDTH-1:0] rem_step;     // remainder after this cycle's steps
  logic              last_cycle;
  logic              handoff;

`ifdef QUOTIENT_EN
  logic [WIDTH-1:0]          quot_reg;
  logic [BITS_PER_CYCLE-1:0] q_bits;   // quotient bits produced this cycle, MSB first
`endif

  assign last_cycle = (state_reg == BUSY) && (cnt_reg == CNT_W'(STEPS - 1));
  assign handoff    = out_valid_reg && out_ready;

  // Unrolled restoring-division steps. Each step appends the next dividend
  // bit to the remainder (DWIDTH+1 bits, so the shift cannot overflow) and
  // subtracts the divisor when it fits. Because the remainder going in is
  // already below the divisor, the result after subtraction fits in DWIDTH
  // bits and the subtraction can be done modulo 2^DWIDTH.
  genvar gi;
  generate
    for (gi = 0; gi < BITS_PER_CYCLE; gi++) begin : step_g
      logic [DWIDTH-1:0] rem_in;
      logic [DWIDTH:0]   shifted;
      logic [DWIDTH-1:0] diff;
      logic [DWIDTH-1:0] rem_out;
      logic              take;

      if (gi == 0) begin : g_src_first
        assign rem_in = rem_reg;
      end else begin : g_src_chain
        assign rem_in = step_g[gi-1].rem_out;
      end

      assign shifted = {rem_in, dvd_reg[WIDTH-1-gi]};
      assign take    = (shifted >= {1'b0, div_reg});
      assign diff    = shifted[DWIDTH-1:0] - div_reg;
      assign rem_out = take ? diff : shifted[DWIDTH-1:0];
`ifdef QUOTIENT_EN
      assign q_bits[BITS_PER_CYCLE-1-gi] = take;
`endif
    end
  endgenerate

  assign rem_step = step_g[BITS_PER_CYCLE-1].rem_out;

  // State register; reset lands in IDLE so in_ready is high during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A zero divisor skips BUSY entirely.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          state_next = (in_div == '0) ? DONE : BUSY;
        end
      end
      BUSY: begin
        if (last_cycle) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (handoff) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-cycle division steps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      dvd_reg <= '0;
      div_reg <= '0;
      rem_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            cnt_reg <= '0;
            dvd_reg <= in_data;
            div_reg <= in_div;
            rem_reg <= '0;
          end
        end
        BUSY: begin
          cnt_reg <= cnt_reg + 1'b1;
          dvd_reg <= dvd_reg << BITS_PER_CYCLE;
          rem_reg <= rem_step;
        end
        default: ;
      endcase
    end
  end

`ifdef QUOTIENT_EN
  // Quotient shift register: new bits enter at the LSB each BUSY cycle.
  // A zero divisor loads all ones as the defined divide-by-zero quotient.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quot_reg <= '0;
    end else begin
      if (state_reg == IDLE && in_valid) begin
        quot_reg <= (in_div == '0) ? '1 : '0;
      end else if (state_reg == BUSY) begin
        quot_reg <= (quot_reg << BITS_PER_CYCLE) | WIDTH'(q_bits);
      end
    end
  end

  assign out_quot = quot_reg;
`endif

  // Result flags. A normal result is flagged valid on the edge that ends
  // the last BUSY cycle. A zero divisor enters DONE on the accepting edge
  // and raises out_valid one edge later, giving it a one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      div0_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            div0_reg <= (in_div == '0);
          end
        end
        BUSY: begin
          if (last_cycle) begin
            out_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (out_ready) begin
            out_valid_reg <= 1'b0;
          end
        end
        default: out_valid_reg <= 1'b0;
      endcase
    end
  end

  assign in_ready  = (state_reg == IDLE);
  assign out_valid = out_valid_reg;
  assign out_rem   = rem_reg;
  assign out_div0  = div0_reg;

endmodule

// File: tb/tb_mod_seq_div.sv
// tb_mod_seq_div: directed self-checking bench for mod_seq_div.
// Two instances share clock and reset: dut_a uses default parameters,
// dut_b uses BITS_PER_CYCLE=4. Quotient checks are active only when the
// QUOTIENT_EN macro is defined.
module tb_mod_seq_div;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  logic        a_in_valid = 1'b0;
  logic        a_in_ready;
  logic [31:0] a_in_data  = '0;
  logic [7:0]  a_in_div   = '0;
  logic        a_out_valid;
  logic        a_out_ready = 1'b0;
  logic [7:0]  a_out_rem;
  logic        a_out_div0;

  logic        b_in_valid = 1'b0;
  logic        b_in_ready;
  logic [31:0] b_in_data  = '0;
  logic [7:0]  b_in_div   = '0;
  logic        b_out_valid;
  logic        b_out_ready = 1'b0;
  logic [7:0]  b_out_rem;
  logic        b_out_div0;

`ifdef QUOTIENT_EN
  logic [31:0] a_out_quot;
  logic [31:0] b_out_quot;
`endif

  mod_seq_div dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .in_div    (a_in_div),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_rem   (a_out_rem),
`ifdef QUOTIENT_EN
    .out_quot  (a_out_quot),
`endif
    .out_div0  (a_out_div0)
  );

  mod_seq_div #(.WIDTH(32), .DWIDTH(8), .BITS_PER_CYCLE(4)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .in_div    (b_in_div),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_rem   (b_out_rem),
`ifdef QUOTIENT_EN
    .out_quot  (b_out_quot),
`endif
    .out_div0  (b_out_div0)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction on instance sel (0 = dut_a, 1 = dut_b):
  // wait for in_ready, present operands for one edge, count edges until
  // out_valid, check the result, then hand it off with a one-cycle out_ready.
  task automatic do_op(input bit sel, input logic [31:0] d, input logic [7:0] v,
                       input int exp_lat, input logic [7:0] exp_rem,
                       input logic [31:0] exp_quot, input bit exp_div0,
                       input string tag);
    int lat;
    int wait_cnt;
    logic [7:0] rem_seen;
    wait_cnt = 0;
    while (!(sel ? b_in_ready : a_in_ready) && wait_cnt < 100) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check({tag, " in_ready"}, 64'(sel ? b_in_ready : a_in_ready), 64'd1);
    if (sel) begin
      b_in_valid = 1'b1; b_in_data = d; b_in_div = v;
    end else begin
      a_in_valid = 1'b1; a_in_data = d; a_in_div = v;
    end
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 0;
    while (!(sel ? b_out_valid : a_out_valid) && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rem_seen = sel ? b_out_rem : a_out_rem;
    check({tag, " latency"}, 64'(lat), 64'(exp_lat));
    check({tag, " rem"}, 64'(rem_seen), 64'(exp_rem));
    check({tag, " div0"}, 64'(sel ? b_out_div0 : a_out_div0), 64'(exp_div0));
`ifdef QUOTIENT_EN
    check({tag, " quot"}, 64'(sel ? b_out_quot : a_out_quot), 64'(exp_quot));
`else
    if (exp_quot == 32'hDEAD_BEEF) $display("%s: quotient not present in this build", tag);
`endif
    $display("%s: in_data=0x%08h in_div=%0d rem=%0d latency=%0d", tag, d, v, rem_seen, lat);
    if (sel) b_out_ready = 1'b1; else a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    b_out_ready = 1'b0;
    check({tag, " valid after handoff"}, 64'(sel ? b_out_valid : a_out_valid), 64'd0);
    check({tag, " ready after handoff"}, 64'(sel ? b_in_ready : a_in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] d;
    int valid_seen;
    int wait_cnt;

    // Reset: asynchronous assertion, values checked before any clock edge.
    #1 rst_n = 1'b0;
    #1;
    check("reset in_ready", 64'(a_in_ready), 64'd1);
    check("reset out_valid", 64'(a_out_valid), 64'd0);
    check("reset out_rem", 64'(a_out_rem), 64'd0);
    check("reset out_div0", 64'(a_out_div0), 64'd0);
`ifdef QUOTIENT_EN
    check("reset out_quot", 64'(a_out_quot), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    check("post-reset in_ready", 64'(a_in_ready), 64'd1);

    // Directed vectors, default configuration (32-cycle latency).
    do_op(1'b0, 32'hFFFF_FFFF, 8'd3,   32, 8'd0,   32'h5555_5555, 1'b0, "a ffffffff/3");
    do_op(1'b0, 32'hFFFE_795F, 8'd3,   32, 8'd2,   32'd1431622431, 1'b0, "a fffe795f/3");
    do_op(1'b0, 32'd1000,      8'd7,   32, 8'd6,   32'd142,       1'b0, "a 1000/7");
    do_op(1'b0, 32'hFFFF_FFFF, 8'd255, 32, 8'd0,   32'h0101_0101, 1'b0, "a ffffffff/255");
    do_op(1'b0, 32'd12345,     8'd200, 32, 8'd145, 32'd61,        1'b0, "a 12345/200");
    do_op(1'b0, 32'd5,         8'd9,   32, 8'd5,   32'd0,         1'b0, "a 5/9");
    do_op(1'b0, 32'd0,         8'd1,   32, 8'd0,   32'd0,         1'b0, "a 0/1");
    do_op(1'b0, 32'h0000_1234, 8'd0,   1,  8'd0,   32'hFFFF_FFFF, 1'b1, "a 1234/0");
    do_op(1'b0, 32'd100,       8'd10,  32, 8'd0,   32'd10,        1'b0, "a 100/10 after div0");

    // BITS_PER_CYCLE=4 instance (8-cycle latency).
    do_op(1'b1, 32'd1000,      8'd7,   8,  8'd6,   32'd142,       1'b0, "b 1000/7");
    do_op(1'b1, 32'hFFFF_FFFF, 8'd3,   8,  8'd0,   32'h5555_5555, 1'b0, "b ffffffff/3");
    do_op(1'b1, 32'h0000_1234, 8'd0,   1,  8'd0,   32'hFFFF_FFFF, 1'b1, "b 1234/0");

    // Divide-by-3 sweeps: start and end of the range following 0xFFFE795F.
    for (int i = 1; i <= 200; i++) begin
      d = 32'hFFFE_795F + 32'(i);
      do_op(1'b1, d, 8'd3, 8, 8'(d % 3), d / 3, 1'b0, "b sweep lo");
    end
    for (int i = 99900; i <= 100000; i++) begin
      d = 32'hFFFE_795F + 32'(i);
      do_op(1'b1, d, 8'd3, 8, 8'(d % 3), d / 3, 1'b0, "b sweep hi");
    end
    for (int i = 1; i <= 16; i++) begin
      d = 32'hFFFE_795F + 32'(i);
      do_op(1'b0, d, 8'd3, 32, 8'(d % 3), d / 3, 1'b0, "a sweep");
    end

    // Backpressure: hold out_ready low in DONE while in_valid toggles.
    a_in_valid = 1'b1; a_in_data = 32'h1234_5678; a_in_div = 8'd10;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    wait_cnt = 0;
    while (!a_out_valid && wait_cnt < 200) begin
      @(posedge clk); #1;
      wait_cnt++;
    end
    check("bp latency", 64'(wait_cnt), 64'd32);
    for (int i = 0; i < 5; i++) begin
      a_in_valid = ~a_in_valid;
      a_in_data  = 32'(i * 7 + 1);
      a_in_div   = 8'd0;
      @(posedge clk); #1;
      check("bp out_valid", 64'(a_out_valid), 64'd1);
      check("bp in_ready", 64'(a_in_ready), 64'd0);
      check("bp out_rem", 64'(a_out_rem), 64'd6);
      check("bp out_div0", 64'(a_out_div0), 64'd0);
`ifdef QUOTIENT_EN
      check("bp out_quot", 64'(a_out_quot), 64'h01D2_08A5);
`endif
    end
    $display("bp: in_data=0x12345678 in_div=10 rem=%0d held for 5 cycles", a_out_rem);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    check("bp release in_ready", 64'(a_in_ready), 64'd1);
    check("bp release out_valid", 64'(a_out_valid), 64'd0);

    // Reset in the middle of BUSY: immediate effect, no result emitted.
    a_in_valid = 1'b1; a_in_data = 32'hFFFF_FFFF; a_in_div = 8'd3;
    @(posedge clk); #1;
    a_in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midreset out_valid", 64'(a_out_valid), 64'd0);
    check("midreset in_ready", 64'(a_in_ready), 64'd1);
    check("midreset out_rem", 64'(a_out_rem), 64'd0);
    #4 rst_n = 1'b1;
    valid_seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (a_out_valid) valid_seen++;
    end
    check("midreset no result", 64'(valid_seen), 64'd0);
    $display("midreset: in-flight operation discarded");
    do_op(1'b0, 32'd1000, 8'd7, 32, 8'd6, 32'd142, 1'b0, "a 1000/7 after reset");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mod_seq_div.md
# mod_seq_div

Sequential, parametrised remainder/quotient unit: the multi-cycle successor to our fixed divide-by-3 combinational checker. It divides a WIDTH-bit unsigned operand by a runtime DWIDTH-bit divisor using MSB-first restoring division, retiring BITS_PER_CYCLE quotient bits per clock. Operands enter and results leave over valid/ready handshakes, so the block can sit between a streaming producer and a checker or accumulator.

## Interface
- WIDTH, 32, dividend width in bits; must be a multiple of BITS_PER_CYCLE
- DWIDTH, 8, divisor and remainder width in bits; 2 ≤ DWIDTH ≤ WIDTH
- BITS_PER_CYCLE, 1, restoring steps per clock; must be one of 1, 2, 4 or 8
- clk  input  1  clock, rising-edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operands
- in_data  input  WIDTH  unsigned dividend
- in_div  input  DWIDTH  unsigned divisor
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_rem  output  DWIDTH  remainder, in_data % in_div
- out_quot  output  WIDTH  quotient, in_data / in_div (QUOTIENT_EN only)
- out_div0  output  1  divisor was zero

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: in_ready=1. When in_valid is high, the block latches in_data and in_div, clears the partial remainder and clears step counter cnt. Next state is BUSY, or DONE if in_div==0.
- BUSY: in_ready=0. Each cycle performs BITS_PER_CYCLE steps, taking dividend bits MSB first.
  - Per step: r = {r, next bit}; if r ≥ div, then r = r − div and the quotient bit is 1; otherwise the quotient bit is 0.
  - r is held in DWIDTH+1 bits internally so the shift cannot overflow.
  - The quotient shifts in from the LSB.
  - cnt counts cycles. After cycle WIDTH/BITS_PER_CYCLE completes, the state moves to DONE.
- DONE: out_valid=1; out_rem = r[DWIDTH-1:0]. When out_ready is high, next state is IDLE.
- Divide by zero: the block skips BUSY and enters DONE with out_div0=1, out_rem=0 and out_quot all ones.
- out_div0 is 0 for every non-zero divisor.
- Outputs are registered and remain stable throughout DONE, whatever in_* is doing.
- in_valid is ignored outside IDLE. No operand is queued.

## Timing
- Reset values: state=IDLE, out_valid=0, out_rem=0, out_quot=0, out_div0=0, cnt=0, all internal registers 0. in_ready=1 during and after reset.
- Latency, counted from the accepting edge (in_valid && in_ready) to the edge that raises out_valid: WIDTH/BITS_PER_CYCLE cycles. For example, 32 cycles with defaults, or 8 cycles with BITS_PER_CYCLE=4.
- Divide-by-zero latency: 1 cycle.
- Result handoff: out_valid && out_ready at edge N. out_valid is low after N, and in_ready is high after N.
  - Throughput is one operation per WIDTH/BITS_PER_CYCLE + 2 cycles when out_ready is held high.
- Backpressure: out_valid stays high and out_rem, out_quot and out_div0 stay frozen for as long as out_ready is low.
- Reset mid-operation: an rst_n assertion in any state forces the reset values immediately, without waiting for clk. The in-flight result is discarded and never signalled.
- cnt is wide enough for WIDTH/BITS_PER_CYCLE; it does not wrap before the transition to DONE.

## Configuration
- QUOTIENT_EN defined: out_quot port and the quotient shift register are present, holding the full WIDTH-bit quotient.
- QUOTIENT_EN undefined:
  - out_quot port and quotient register are removed; remainder-only operation.
  - Remainder behaviour, latency and handshake are identical in both builds.

## Test plan
- Defaults, in_data=0xFFFFFFFF, in_div=3 -> out_valid 32 cycles after accept; out_rem=0; out_quot=0x55555555; out_div0=0.
- Defaults, in_data=0xFFFE795F (2^32−1−100000), in_div=3 -> out_rem=2.
  - Sweep the following 100000 consecutive values with in_div=3; every out_rem must equal in_data % 3, matching the legacy divide-by-3 checker.
- in_data=1000, in_div=7, BITS_PER_CYCLE=4 -> out_rem=6, out_quot=142, out_valid exactly 8 cycles after accept.
- in_div=0, in_data=0x1234 -> out_valid 1 cycle after accept; out_div0=1; out_rem=0; out_quot=0xFFFFFFFF.
- Hold out_ready=0 for 5 cycles in DONE, with in_valid toggling -> outputs stable, in_ready=0 throughout.
  - Then out_ready=1 -> in_ready=1 on the next cycle.
- Assert rst_n low for half a cycle at cycle 10 of BUSY -> out_valid=0 and in_ready=1 immediately, with no result emitted.
  - A new operation then completes with the correct result.
